// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one external combinational
// WIDTH x WIDTH multiplier between NUM_REQ requesters. One operation is in
// flight at a time: grant, hold operands for MULT_LAT cycles, sample the
// product, then return it on a tagged response channel with backpressure.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   S_IDLE | no operation in flight; round-robin grant offered to requesters
//   S_WAIT | operands held on the multiplier, latency counter running down
//   S_RESP | product registered, response valid until the consumer takes it

module mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 9,
  parameter int MULT_LAT = 1,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic [2*WIDTH-1:0]         mult_y,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [2*WIDTH-1:0]         resp_y,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter reload: WAIT then lasts exactly MULT_LAT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LAT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              accept;
  logic              capture;
  logic              resp_done;

  // Position of the requester that sits 'offs' slots after 'base' in the ring.
  function automatic logic [ID_W-1:0] ring_idx(input logic [ID_W-1:0] base,
                                                input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Successor of a requester index, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] ring_inc(input logic [ID_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && req_valid[ring_idx(rr_ptr, i)]) begin
        grant_vld = 1'b1;
        grant_idx = ring_idx(rr_ptr, i);
      end
    end
  end

  // Operand slice belonging to the current grant candidate.
  always_comb begin
    op_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    op_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_vld)      state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0)    state_d = S_RESP;
      S_RESP:  if (resp_ready)     state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Output decode: handshake strobes and the one-hot ready vector.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    resp_done = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        // Ready is also masked during reset so nobody sees a phantom accept.
        if (grant_vld && !rst) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          accept    = 1'b1;
        end
      end
      S_WAIT:  capture   = (cnt_q == '0);
      S_RESP:  resp_done = resp_ready;
      default: ;
    endcase
  end

  // Operand registers, grant register and latency down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a  <= '0;
      mult_b  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      mult_a  <= op_a;
      mult_b  <= op_b;
      grant_q <= grant_idx;
      cnt_q   <= CNT_LOAD;
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  // Response registers: product sampled at terminal count, held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_y     <= '0;
      resp_id    <= '0;
    end else if (capture) begin
      resp_valid <= 1'b1;
      resp_y     <= mult_y;
      resp_id    <= grant_q;
    end else if (resp_done) begin
      resp_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the served requester only on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr <= '0;
    else if (resp_done) rr_ptr <= ring_inc(grant_q);
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter (MULT_LAT=1 instance with
// a reference model monitor) plus a directed MULT_LAT=3 instance.

module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 9;

  logic        clk;
  logic        rst;

  // Instance with default latency
  logic [N-1:0]   rv;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a_bus;
  logic [N*W-1:0] req_b_bus;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic [2*W-1:0] mult_y;
  logic           resp_valid;
  logic           resp_rdy;
  logic [1:0]     resp_id;
  logic [2*W-1:0] resp_y;
  logic           busy;

  // Instance with MULT_LAT=3
  logic [N-1:0]   rv3;
  logic [N-1:0]   req_ready3;
  logic [N*W-1:0] a3_bus;
  logic [N*W-1:0] b3_bus;
  logic [W-1:0]   mult_a3;
  logic [W-1:0]   mult_b3;
  logic [2*W-1:0] mult_y3;
  logic           resp_valid3;
  logic           resp_rdy3;
  logic [1:0]     resp_id3;
  logic [2*W-1:0] resp_y3;
  logic           busy3;

  logic [W-1:0] a_op [N];
  logic [W-1:0] b_op [N];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] y;
  } exp_t;

  exp_t           sb [$];
  int             resp_id_log [$];
  logic [2*W-1:0] resp_y_log [$];

  bit m_busy = 0;
  bit m_seen = 0;
  int m_ptr  = 0;
  int m_lat  = 0;

  mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .MULT_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(rv), .req_ready(req_ready),
    .req_a(req_a_bus), .req_b(req_b_bus),
    .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y),
    .resp_valid(resp_valid), .resp_ready(resp_rdy),
    .resp_id(resp_id), .resp_y(resp_y), .busy(busy)
  );

  mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .MULT_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(rv3), .req_ready(req_ready3),
    .req_a(a3_bus), .req_b(b3_bus),
    .mult_a(mult_a3), .mult_b(mult_b3), .mult_y(mult_y3),
    .resp_valid(resp_valid3), .resp_ready(resp_rdy3),
    .resp_id(resp_id3), .resp_y(resp_y3), .busy(busy3)
  );

  // Combinational multipliers standing in for the shared instance
  assign mult_y  = 18'(mult_a)  * 18'(mult_b);
  assign mult_y3 = 18'(mult_a3) * 18'(mult_b3);

  always_comb begin
    req_a_bus = '0;
    req_b_bus = '0;
    for (int i = 0; i < N; i++) begin
      req_a_bus[i*W +: W] = a_op[i];
      req_b_bus[i*W +: W] = b_op[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (ptr + i) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference monitor: round-robin model, latency and response scoreboard
  initial begin
    exp_t cur;
    int g;
    logic [N-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        m_busy = 0;
        m_seen = 0;
        m_ptr  = 0;
      end else if (!m_busy) begin
        g = rr_pick(rv, m_ptr);
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        check("idle_busy", 32'(busy), 0);
        check("idle_resp_valid", 32'(resp_valid), 0);
        check("grant", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
          cur.id = g;
          cur.a  = a_op[g];
          cur.b  = b_op[g];
          cur.y  = 18'(a_op[g]) * 18'(b_op[g]);
          sb.push_back(cur);
          m_busy = 1;
          m_seen = 0;
          m_lat  = 0;
        end
      end else begin
        cur = sb[0];
        check("busy", 32'(busy), 1);
        check("ready_when_busy", 32'(req_ready), 0);
        check("mult_a_hold", 32'(mult_a), 32'(cur.a));
        check("mult_b_hold", 32'(mult_b), 32'(cur.b));
        if (!m_seen && !resp_valid) begin
          m_lat++;
        end else begin
          if (!m_seen) begin
            check("latency", m_lat, 1);
            m_seen = 1;
          end
          check("resp_valid_hold", 32'(resp_valid), 1);
          check("resp_y", 32'(resp_y), 32'(cur.y));
          check("resp_id", 32'(resp_id), cur.id);
          if (resp_rdy) begin
            void'(sb.pop_front());
            resp_id_log.push_back(cur.id);
            resp_y_log.push_back(cur.y);
            m_ptr  = (cur.id + 1) % N;
            m_busy = 0;
            m_seen = 0;
          end
        end
      end
    end
  end

  // Raise one request and drop it right after the accepting edge.
  task automatic do_req(input int id, input int a, input int b);
    bit got;
    a_op[id] = W'(a);
    b_op[id] = W'(b);
    rv[id]   = 1'b1;
    got      = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", 32'(req_ready[id]), 1);
    @(posedge clk); #1;
    rv[id] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!m_busy) return;
      @(posedge clk); #1;
    end
    check("done_timeout", 32'(m_busy), 0);
  endtask

  task automatic wait_log(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (resp_id_log.size() >= target) return;
      @(posedge clk); #1;
    end
    check("log_timeout", resp_id_log.size(), target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got %0d tests expected finish", n_tests);
    $fatal(1);
  end

  initial begin
    int base;
    int exp_ids [5];
    int exp_ys [5];
    exp_ids = '{0, 1, 2, 3, 0};
    exp_ys  = '{10, 20, 30, 40, 10};

    rst       = 1'b1;
    rv        = '1;
    rv3       = '1;
    resp_rdy  = 1'b1;
    resp_rdy3 = 1'b0;
    a3_bus    = '0;
    b3_bus    = '0;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end

    // Reset values, with requests pending to show ready stays low
    #12;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mult_a", 32'(mult_a), 0);
    check("rst_mult_b", 32'(mult_b), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_y", 32'(resp_y), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready3", 32'(req_ready3), 0);
    check("rst_busy3", 32'(busy3), 0);
    rv  = '0;
    rv3 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single operations from requester 0
    base = resp_id_log.size();
    do_req(0, 2, 2);
    wait_done(20);
    do_req(0, 4, 4);
    wait_done(20);
    check("t1_count", resp_id_log.size() - base, 2);
    check("t1_y0", 32'(resp_y_log[base]), 4);
    check("t1_id0", resp_id_log[base], 0);
    check("t1_y1", 32'(resp_y_log[base+1]), 16);

    // 2: max operands on requester 3
    base = resp_id_log.size();
    do_req(3, 511, 511);
    wait_done(20);
    check("t2_y", 32'(resp_y_log[base]), 261121);
    check("t2_id", resp_id_log[base], 3);

    // 3: all requesters continuously valid
    base = resp_id_log.size();
    for (int i = 0; i < N; i++) begin
      a_op[i] = W'(i + 1);
      b_op[i] = W'(10);
    end
    rv = '1;
    wait_log(base + 5, 40);
    rv = '0;
    wait_done(20);
    check("t3_count", resp_id_log.size() - base, 5);
    for (int k = 0; k < 5; k++) begin
      check("t3_id", resp_id_log[base+k], exp_ids[k]);
      check("t3_y", 32'(resp_y_log[base+k]), exp_ys[k]);
    end

    // 4: backpressure with a competing request queued behind it
    resp_rdy = 1'b0;
    do_req(1, 5, 6);
    a_op[2] = W'(3);
    b_op[2] = W'(3);
    rv[2]   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    repeat (5) @(negedge clk);
    check("t4_valid_held", 32'(resp_valid), 1);
    check("t4_y_held", 32'(resp_y), 30);
    check("t4_id_held", 32'(resp_id), 1);
    check("t4_no_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_resume", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    rv[2] = 1'b0;
    wait_done(20);

    // 5: MULT_LAT=3 instance, requester 1
    a3_bus[W +: W] = W'(7);
    b3_bus[W +: W] = W'(9);
    resp_rdy3 = 1'b1;
    rv3 = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready3 != '0) break;
    end
    check("t5_grant", 32'(req_ready3), 32'h2);
    @(posedge clk); #1;
    rv3 = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t5_mult_a", 32'(mult_a3), 7);
      check("t5_mult_b", 32'(mult_b3), 9);
      check("t5_wait_no_resp", 32'(resp_valid3), 0);
    end
    @(negedge clk);
    check("t5_resp_valid", 32'(resp_valid3), 1);
    check("t5_resp_y", 32'(resp_y3), 63);
    check("t5_resp_id", 32'(resp_id3), 1);
    @(negedge clk);
    check("t5_idle", 32'(busy3), 0);
    @(posedge clk); #1;

    // 6: reset in the middle of WAIT
    base = resp_id_log.size();
    do_req(0, 3, 5);
    rst = 1'b1;
    a_op[2] = W'(6);
    b_op[2] = W'(7);
    a_op[3] = W'(8);
    b_op[3] = W'(2);
    rv = 4'b1100;
    #1;
    check("t6_mult_a", 32'(mult_a), 0);
    check("t6_mult_b", 32'(mult_b), 0);
    check("t6_resp_valid", 32'(resp_valid), 0);
    check("t6_resp_y", 32'(resp_y), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_log(base + 1, 20);
    rv = '0;
    wait_done(20);
    check("t6_id", resp_id_log[base], 2);
    check("t6_y", 32'(resp_y_log[base]), 42);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
